div_unit: RTL
=============

# div_unit

Iterative 32-bit MIPS divider for DIV/DIVU, in the execute stage directly downstream of the ALU decoder. It is launched by the EX stage when the decoded operation is a divide. It holds the pipeline via `stall_o` while a radix-2 restoring division runs, one quotient bit per cycle. It returns `{remainder, quotient}` for the HI/LO register write.

## Interface
Parameters: none (width fixed at 32).

- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: divide request (level). Held by EX while stalled.
- `signed_div_i` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` input 32: dividend (rs).
- `opdata2_i` input 32: divisor (rt).
- `annul_i` input 1: flush/exception. Cancels any operation in progress.
- `result_o` output 64: `{HI = remainder, LO = quotient}`. Registered.
- `ready_o` output 1: one-cycle pulse. `result_o` is valid in this cycle.
- `stall_o` output 1: pipeline stall request.

## Operation
- States: IDLE, DIVZERO, ON, END. Reset value is IDLE, `result_o = 64'h0`, `ready_o = 0`.
- IDLE:
  - If `annul_i` is high, stay in IDLE. `annul_i` has priority over `start_i`.
  - Else, if `start_i` is high and `opdata2_i == 0`, go to DIVZERO.
  - Else, if `start_i` is high, capture operands and go to ON with iteration counter = 0.
- Operand capture:
  - Unsigned: raw values.
  - Signed: absolute values of both operands.
  - Latch `neg_q = sign1 ^ sign2` and `neg_r = sign1` (signed only, else 0).
  - Inputs are ignored after capture.
- ON: one restoring step per cycle on a 65-bit partial remainder register.
  - Shift left by 1.
  - Trial-subtract the divisor from bits [64:32].
  - If the result is non-negative, keep it and set the new LSB to 1; else set the LSB to 0.
  - Counter increments 0→32. When the 32nd step completes, go to END.
- Sign fix-up, applied on entry to END:
  - Quotient is negated if `neg_q`.
  - Remainder is negated if `neg_r`.
  - Both are written into `result_o`.
- Special cases:
  - Signed `0x80000000 / 0xFFFFFFFF` gives quotient 0x80000000 (wraps) and remainder 0. No trap.
  - Division by zero (DIVZERO state) writes `result_o = 64'h0`, then goes to END. No trap.
- END: `ready_o = 1` for exactly this cycle, then go unconditionally to IDLE.
  - If `start_i` is still high in the following IDLE cycle, that is treated as a new request.
- `annul_i` in DIVZERO, ON or END:
  - Next state is IDLE.
  - `ready_o` is forced to 0 in the same cycle. It is combinational with the END state, gated by `!annul_i`.
  - `result_o` keeps its previous value.
- `result_o` changes only on entry to END. It holds between operations.
- `stall_o = (state==IDLE & start_i & !annul_i) | state==DIVZERO | state==ON`. It is low in END.

## Timing
- Let cycle N be an IDLE cycle with `start_i = 1`.
  - Divisor ≠ 0: ON in cycles N+1..N+32, END (`ready_o = 1`) in N+33, `stall_o` high in N..N+32. This is 33 stall cycles.
  - Divisor = 0: DIVZERO in N+1, END in N+2, `stall_o` high in N..N+1.
- Back-to-back divides have one IDLE cycle between END and the next accept.
- Reset mid-operation: asynchronous return to IDLE and outputs cleared in the same instant. The first request after reset deasserts follows the normal timing.
- There is no combinational path from `opdata*_i` to any output. `stall_o` and `ready_o` depend only on state, `start_i` and `annul_i`.

## Test plan
- DIVU 100 / 7: `ready_o` pulses at N+33, `result_o = {32'd2, 32'd14}`, `stall_o` high for exactly 33 cycles.
- DIV -7 / 2: `result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}`. DIV 7 / -2 gives `{32'h1, 32'hFFFFFFFD}`.
- DIV 0x80000000 / 0xFFFFFFFF gives `{32'h0, 32'h80000000}`. DIVU 0xFFFFFFFF / 1 gives `{32'h0, 32'hFFFFFFFF}`.
- DIVU 5 / 0: `ready_o` at N+2, `result_o = 64'h0`, `stall_o` high for 2 cycles.
- Annul then retry:
  - Start DIVU 100 / 7, assert `annul_i` in cycle N+10. Expect IDLE at N+11, no `ready_o`, `result_o` unchanged.
  - Then issue DIVU 9 / 4. Expect `{32'd1, 32'd2}` 33 cycles after accept.
- Reset mid-op and back-to-back:
  - Assert `rst` in cycle N+20. Expect outputs 0 and IDLE immediately.
  - Then hold `start_i` high for two consecutive divides. Expect two `ready_o` pulses 34 cycles apart.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Holds the pipeline via stall_o and returns {remainder, quotient}.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t      r_state;
    logic [63:0] r_rem;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;

    logic        w_sign1;
    logic        w_sign2;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [64:0] w_shift;
    logic [32:0] w_diff;
    logic [63:0] w_next;
    logic [31:0] w_quot;
    logic [31:0] w_remd;

    assign w_sign1 = signed_div_i & opdata1_i[31];
    assign w_sign2 = signed_div_i & opdata2_i[31];
    assign w_abs1  = w_sign1 ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_abs2  = w_sign2 ? (~opdata2_i + 32'd1) : opdata2_i;

    // Partial remainder lives in [63:32], quotient bits shift in at [0].
    assign w_shift = {r_rem, 1'b0};
    assign w_diff  = w_shift[64:32] - {1'b0, r_dvs};
    assign w_next  = w_diff[32] ? w_shift[63:0]
                                : {w_diff[31:0], w_shift[31:1], 1'b1};

    assign w_quot = r_neg_q ? (~w_next[31:0] + 32'd1) : w_next[31:0];
    assign w_remd = r_neg_r ? (~w_next[63:32] + 32'd1) : w_next[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rem    <= 64'd0;
            r_dvs    <= 32'd0;
            r_cnt    <= 6'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!annul_i && start_i) begin
                        if (opdata2_i == 32'd0) begin
                            r_state <= S_DIVZERO;
                        end else begin
                            r_rem   <= {32'd0, w_abs1};
                            r_dvs   <= w_abs2;
                            r_neg_q <= w_sign1 ^ w_sign2;
                            r_neg_r <= w_sign1;
                            r_cnt   <= 6'd0;
                            r_state <= S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= 64'd0;
                        r_state  <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_result <= {w_remd, w_quot};
                            r_state  <= S_END;
                        end
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == S_END) & ~annul_i;
    assign stall_o  = ((r_state == S_IDLE) & start_i & ~annul_i)
                    | (r_state == S_DIVZERO)
                    | (r_state == S_ON);

endmodule
